// File: rtl/slow_clk_meter.sv
// Measures the period of a slow, asynchronous clock in reference ticks and
// decodes which power-of-two prog mode it corresponds to, with lock and timeout flags.
`timescale 1ns/1ps
module slow_clk_meter #(
  parameter int TICK_CYC   = 1_000_000,
  parameter int BASE_TICKS = 10,
  parameter int MAX_TICKS  = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_in,
  input  logic [2:0]  prog_exp,
  output logic [11:0] period,
  output logic [2:0]  mode_det,
  output logic        meas_valid,
  output logic        locked,
  output logic        mismatch,
  output logic        timeout,
  output logic        dbg_state
);
  localparam int            PW         = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
  localparam logic [11:0]   CNT_MAX    = 12'(MAX_TICKS);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          sync0_q, sync1_q, sync2_q;
  logic          rise, tick;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   cnt_q, cnt_d, period_new;
  logic [11:0]   period_q;
  logic [2:0]    mode_q, hist_mode_q;
  logic          valid_q, locked_q, mismatch_q, timeout_q, hist_ok_q;
  logic          do_meas, do_timeout, dec_ok;
  logic [2:0]    dec_mode;

  // Returns {ok, k}: ok when the period is within one tick of BASE_TICKS<<k.
  function automatic logic [3:0] decode(input logic [11:0] p);
    logic [3:0] r;
    int         diff;
    r = 4'b0;
    for (int k = 0; k < 8; k++) begin
      diff = int'(p) - (BASE_TICKS << k);
      if (diff >= -1 && diff <= 1) r = {1'b1, 3'(k)};
    end
    return r;
  endfunction

  assign rise       = sync1_q & ~sync2_q;
  assign tick       = (presc_q == PRESC_LAST);
  // A tick landing in the same cycle as the closing edge still belongs to this period.
  assign period_new = cnt_q + {11'd0, tick};
  assign {dec_ok, dec_mode} = decode(period_new);

  always_comb begin
    state_d    = state_q;
    do_meas    = 1'b0;
    do_timeout = 1'b0;
    presc_d    = (rise || tick) ? '0 : presc_q + PW'(1);
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          do_meas = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          do_timeout = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else if (tick) begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync0_q     <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      presc_q     <= '0;
      cnt_q       <= '0;
      period_q    <= '0;
      mode_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
      hist_ok_q   <= 1'b0;
      hist_mode_q <= '0;
    end else begin
      sync0_q <= clk_in;
      sync1_q <= sync0_q;
      sync2_q <= sync1_q;
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      valid_q <= do_meas;
      if (state_q == IDLE) hist_ok_q <= 1'b0;
      if (do_meas) begin
        period_q   <= period_new;
        timeout_q  <= 1'b0;
        mismatch_q <= !dec_ok || (dec_mode != prog_exp);
        if (dec_ok) begin
          mode_q      <= dec_mode;
          locked_q    <= hist_ok_q && (hist_mode_q == dec_mode);
          hist_ok_q   <= 1'b1;
          hist_mode_q <= dec_mode;
        end else begin
          locked_q  <= 1'b0;
          hist_ok_q <= 1'b0;
        end
      end
      if (do_timeout) begin
        timeout_q  <= 1'b1;
        locked_q   <= 1'b0;
        mismatch_q <= 1'b1;
        hist_ok_q  <= 1'b0;
      end
    end
  end

  assign period     = period_q;
  assign mode_det   = mode_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_slow_clk_meter.sv
// Bench for slow_clk_meter with small tick parameters; expected reports are
// queued when a clk_in rise is driven and popped when meas_valid fires.
`timescale 1ns/1ps
module tb_slow_clk_meter;
  logic        clk = 1'b0;
  logic        rst;
  logic        clk_in;
  logic [2:0]  prog_exp;
  logic [11:0] period;
  logic [2:0]  mode_det;
  logic        meas_valid, locked, mismatch, timeout, dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  // {period[11:0], mode_det[2:0], mismatch, locked, timeout}
  logic [17:0] exp_q[$];

  slow_clk_meter #(.TICK_CYC(10), .BASE_TICKS(10), .MAX_TICKS(4000)) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .prog_exp(prog_exp),
    .period(period), .mode_det(mode_det), .meas_valid(meas_valid),
    .locked(locked), .mismatch(mismatch), .timeout(timeout), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // One clk_in period of per cycles starting with a rise, driven on negedges.
  task automatic pulse(input int per);
    clk_in = 1'b1;
    repeat (per / 2) @(negedge clk);
    clk_in = 1'b0;
    repeat (per - per / 2) @(negedge clk);
  endtask

  task automatic do_reset();
    clk_in = 1'b0;
    rst    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    clk_in   = 1'b0;
    prog_exp = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      clk_in = ~clk_in;
      @(negedge clk);
      n_checks++;
      if ({period, mode_det, meas_valid, locked, mismatch, timeout, dbg_state} !== 21'd0)
        $display("FAIL reset_outputs: got %h required 0",
                 {period, mode_det, meas_valid, locked, mismatch, timeout, dbg_state});
      else n_pass++;
    end
    clk_in = 1'b0;
    rst    = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({meas_valid, dbg_state} !== 2'b00)
      $display("FAIL reset_release_idle: got %b required 00", {meas_valid, dbg_state});
    else n_pass++;
  endtask

  task automatic test_mode0();
    do_reset();
    prog_exp = 3'd0;
    pulse(100);
    exp_q.push_back({12'd10, 3'd0, 1'b0, 1'b0, 1'b0});
    pulse(100);
    exp_q.push_back({12'd10, 3'd0, 1'b0, 1'b1, 1'b0});
    pulse(100);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL mode0_drain: %0d reports missing, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_mode3_jitter();
    do_reset();
    prog_exp = 3'd3;
    pulse(800);
    exp_q.push_back({12'd80, 3'd3, 1'b0, 1'b0, 1'b0});
    pulse(800);
    exp_q.push_back({12'd80, 3'd3, 1'b0, 1'b1, 1'b0});
    pulse(790);
    exp_q.push_back({12'd79, 3'd3, 1'b0, 1'b1, 1'b0});
    pulse(810);
    exp_q.push_back({12'd81, 3'd3, 1'b0, 1'b1, 1'b0});
    pulse(800);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL mode3_drain: %0d reports missing, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bad_period();
    do_reset();
    prog_exp = 3'd1;
    pulse(200);
    exp_q.push_back({12'd20, 3'd1, 1'b0, 1'b0, 1'b0});
    pulse(130);
    exp_q.push_back({12'd13, 3'd1, 1'b1, 1'b0, 1'b0});
    pulse(200);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL bad_period_drain: %0d reports missing, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int waited;
    do_reset();
    prog_exp = 3'd0;
    pulse(100);
    exp_q.push_back({12'd10, 3'd0, 1'b0, 1'b0, 1'b0});
    pulse(100);
    exp_q.push_back({12'd10, 3'd0, 1'b0, 1'b1, 1'b0});
    clk_in = 1'b1;
    repeat (50) @(negedge clk);
    clk_in = 1'b0;
    repeat (38950) @(negedge clk);
    n_checks++;
    if (timeout !== 1'b0) $display("FAIL timeout_early: got %b required 0", timeout);
    else n_pass++;
    waited = 0;
    while (timeout !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (timeout !== 1'b1) $display("FAIL timeout_seen: got %b required 1 within bound", timeout);
    else n_pass++;
    n_checks++;
    if ({timeout, locked, mismatch, dbg_state} !== 4'b1010)
      $display("FAIL timeout_flags: got %b required 1010", {timeout, locked, mismatch, dbg_state});
    else n_pass++;
    n_checks++;
    if ({period, mode_det} !== {12'd10, 3'd0})
      $display("FAIL timeout_hold: got period=%0d mode=%0d required 10/0", period, mode_det);
    else n_pass++;
    prog_exp = 3'd1;
    pulse(200);
    n_checks++;
    if (timeout !== 1'b1) $display("FAIL timeout_sticky: got %b required 1", timeout);
    else n_pass++;
    exp_q.push_back({12'd20, 3'd1, 1'b0, 1'b0, 1'b0});
    pulse(200);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL timeout_drain: %0d reports missing, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_mode_change();
    do_reset();
    prog_exp = 3'd0;
    pulse(100);
    exp_q.push_back({12'd10, 3'd0, 1'b0, 1'b0, 1'b0});
    pulse(100);
    exp_q.push_back({12'd10, 3'd0, 1'b0, 1'b1, 1'b0});
    pulse(200);
    exp_q.push_back({12'd20, 3'd1, 1'b1, 1'b0, 1'b0});
    pulse(200);
    exp_q.push_back({12'd20, 3'd1, 1'b1, 1'b1, 1'b0});
    pulse(200);
    prog_exp = 3'd1;
    exp_q.push_back({12'd20, 3'd1, 1'b0, 1'b1, 1'b0});
    clk_in = 1'b1;
    repeat (60) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clk_in = ~clk_in;
      n_checks++;
      if ({period, mode_det, meas_valid, locked, mismatch, timeout, dbg_state} !== 21'd0)
        $display("FAIL midreset_outputs: got %h required 0",
                 {period, mode_det, meas_valid, locked, mismatch, timeout, dbg_state});
      else n_pass++;
    end
    clk_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    pulse(200);
    n_checks++;
    if ({period, meas_valid} !== 13'd0)
      $display("FAIL first_rise_silent: got period=%0d valid=%b required 0/0", period, meas_valid);
    else n_pass++;
    exp_q.push_back({12'd20, 3'd1, 1'b0, 1'b0, 1'b0});
    pulse(200);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL mode_change_drain: %0d reports missing, required 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    logic [17:0] exp_v;
    logic [17:0] got_v;
    rst      = 1'b0;
    clk_in   = 1'b0;
    prog_exp = 3'd0;
    fork
      forever begin
        @(negedge clk);
        if (rst === 1'b1 && meas_valid === 1'b1) begin
          got_v = {period, mode_det, mismatch, locked, timeout};
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_meas_valid: got report %h required none", got_v);
          end else begin
            exp_v = exp_q.pop_front();
            if (got_v !== exp_v)
              $display("FAIL meas_report: got period=%0d mode=%0d mm=%b lk=%b to=%b required period=%0d mode=%0d mm=%b lk=%b to=%b",
                       got_v[17:6], got_v[5:3], got_v[2], got_v[1], got_v[0],
                       exp_v[17:6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
            else n_pass++;
          end
        end
      end
    join_none
    test_reset();
    test_mode0();
    test_mode3_jitter();
    test_bad_period();
    test_timeout();
    test_mode_change();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
